// File: rtl/if_queue_if.sv
// Fetch-queue bus bundle: redirect requests, instruction-memory handshake and decode handshake.
interface if_queue_if;
  localparam int unsigned W_ADDR = 32;
  localparam int unsigned W_INST = 32;

  logic              except;
  logic [W_ADDR-1:0] except_addr;
  logic              branch;
  logic [W_ADDR-1:0] branch_addr;
  logic              imem_req;
  logic [W_ADDR-1:0] imem_addr;
  logic              imem_addr_ok;
  logic              imem_data_ok;
  logic [W_INST-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [W_ADDR-1:0] out_pc;
  logic [W_INST-1:0] out_inst;

  modport master (
    input  except, except_addr, branch, branch_addr,
    input  imem_addr_ok, imem_data_ok, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output except, except_addr, branch, branch_addr,
    output imem_addr_ok, imem_data_ok, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses for decode,
// and flushes on branch/exception redirects while discarding responses already in flight.
module if_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_queue_if.master q
);
  localparam int unsigned W_ADDR = 32;
  localparam int unsigned W_INST = 32;
  localparam int unsigned W_IDX  = $clog2(DEPTH);
  localparam int unsigned W_PTR  = W_IDX + 1;
  localparam int unsigned W_DROP = $clog2(DEPTH + 1) + 1;

  logic [W_ADDR-1:0] fetch_pc;
  logic [W_PTR-1:0]  alloc_ptr;
  logic [W_PTR-1:0]  fill_ptr;
  logic [W_PTR-1:0]  head_ptr;
  logic [W_DROP-1:0] drop_cnt;
  logic [W_DROP-1:0] drop_cnt_nxt;
  logic [W_ADDR-1:0] slot_pc   [DEPTH];
  logic [W_INST-1:0] slot_inst [DEPTH];

  logic              redirect;
  logic [W_ADDR-1:0] target;
  logic [W_PTR-1:0]  in_use;
  logic [W_PTR-1:0]  pending;
  logic              valid;
  logic              pop;
  logic              req;
  logic              issue;
  logic              drop;
  logic              fill;

  // Slot state lives in the pointers: [fill,alloc) are PENDING, [head,fill) are FILLED.
  always_comb begin
    redirect = q.except | q.branch;
    target   = q.except ? q.except_addr : q.branch_addr;
    in_use   = alloc_ptr - head_ptr;
    pending  = alloc_ptr - fill_ptr;
    valid    = (fill_ptr != head_ptr);
    pop      = valid & q.out_ready & ~redirect;
    // A same-cycle pop frees the slot the new request will occupy.
    req      = rst & ~redirect & ((in_use < W_PTR'(DEPTH)) | pop);
    issue    = req & q.imem_addr_ok;
    drop     = q.imem_data_ok & (drop_cnt != '0);
    fill     = q.imem_data_ok & (drop_cnt == '0) & ~redirect;
  end

  // Responses still owed to flushed slots; a response arriving in the flush cycle is netted out.
  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (redirect) begin
      drop_cnt_nxt = drop_cnt + W_DROP'(pending) - W_DROP'(q.imem_data_ok);
    end else if (drop) begin
      drop_cnt_nxt = drop_cnt - W_DROP'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[W_IDX'(i)]   <= '0;
        slot_inst[W_IDX'(i)] <= '0;
      end
    end else begin
      drop_cnt <= drop_cnt_nxt;
      if (redirect) begin
        fetch_pc  <= target;
        alloc_ptr <= head_ptr;
        fill_ptr  <= head_ptr;
      end else begin
        if (issue) begin
          slot_pc[alloc_ptr[W_IDX-1:0]] <= fetch_pc;
          alloc_ptr                     <= alloc_ptr + W_PTR'(1);
          fetch_pc                      <= fetch_pc + W_ADDR'(4);
        end
        if (fill) begin
          slot_inst[fill_ptr[W_IDX-1:0]] <= q.imem_rdata;
          fill_ptr                       <= fill_ptr + W_PTR'(1);
        end
        if (pop) begin
          head_ptr <= head_ptr + W_PTR'(1);
        end
      end
    end
  end

  assign q.imem_req  = req;
  assign q.imem_addr = fetch_pc;
  assign q.out_valid = valid;
  assign q.out_pc    = slot_pc[head_ptr[W_IDX-1:0]];
  assign q.out_inst  = slot_inst[head_ptr[W_IDX-1:0]];
endmodule

// File: tb/tb_if_queue.sv
// Bench for if_queue: in-order memory responder tagging requests with a redirect epoch,
// expected-instruction scoreboard, and a separate monitor checking the decode side.
module tb_if_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          MEM_OUTS = 8;

  typedef struct {
    logic [31:0] dut_addr;
    logic [31:0] pc;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  if_queue_if bus ();

  if_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] popped[$];
  int          epoch;
  logic [31:0] model_pc;
  int          tests;
  int          fails;
  int          pop_count;
  int          issue_count;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(2))
      0:       t = 32'hFFFF_FFE0 | 32'($urandom_range(31));
      1:       t = 32'h8000_0000 | 32'($urandom_range(32'hFFFF));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.except       = 1'b0;
    bus.except_addr  = '0;
    bus.branch       = 1'b0;
    bus.branch_addr  = '0;
    bus.imem_addr_ok = 1'b0;
    bus.imem_data_ok = 1'b0;
    bus.imem_rdata   = '0;
    bus.out_ready    = 1'b0;
  endtask

  // Reset DUT and memory together; the expected program stream restarts at RESET_PC.
  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle();
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    mem_q.delete();
    exp_q.delete();
    epoch++;
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One clock of stimulus plus memory responder and fetch-side model.
  task automatic cycle(input bit exc, input logic [31:0] ea, input bit br, input logic [31:0] ba,
                       input bit aok, input bit dok, input bit rdy);
    mreq_t r;
    bit    red;
    bit    live;
    bit    pop;
    bit    exp_req;
    int    cur_pend;
    @(negedge clk);
    bus.except      = exc;
    bus.except_addr = ea;
    bus.branch      = br;
    bus.branch_addr = ba;
    bus.out_ready   = rdy;
    live            = 1'b0;
    bus.imem_data_ok = dok && (mem_q.size() != 0);
    if (bus.imem_data_ok) begin
      r = mem_q.pop_front();
      bus.imem_rdata = mem_fn(r.dut_addr);
      live = (r.epoch == epoch);
    end else begin
      bus.imem_rdata = $urandom;
    end
    bus.imem_addr_ok = aok && (mem_q.size() < MEM_OUTS);
    #1;
    red = exc | br;
    cur_pend = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) cur_pend++;
    if (live) cur_pend++;
    pop = !red && rdy && (exp_q.size() != 0);
    exp_req = !red && ((cur_pend + exp_q.size() - int'(pop)) < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (bus.imem_req && bus.imem_addr_ok) begin
      check("imem_addr", bus.imem_addr, model_pc);
      mem_q.push_back('{bus.imem_addr, model_pc, epoch});
      model_pc += 32'd4;
      issue_count++;
    end
    #2;
    if (red) begin
      epoch++;
      exp_q.delete();
      model_pc = exc ? ea : ba;
    end else if (live) begin
      exp_q.push_back('{r.pc, mem_fn(r.pc)});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic rand_cycle();
    bit exc;
    bit br;
    exc = ($urandom_range(99) < 2);
    br  = ($urandom_range(99) < 4);
    cycle(exc, rand_target(), br, rand_target(),
          $urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 65);
  endtask

  // Decode-side monitor: every presented instruction must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (bus.out_valid && bus.out_ready && !bus.except && !bus.branch) begin
          pop_count++;
          popped.push_back(bus.out_pc);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_pc", bus.out_pc, e.pc);
            check("out_inst", bus.out_inst, e.inst);
          end
        end
      end
    end
  end

  initial begin
    int p0;
    int i0;
    tests = 0;
    fails = 0;
    pop_count = 0;
    issue_count = 0;
    epoch = 0;
    model_pc = RESET_PC;
    rst = 1'b0;
    idle();
    reset_dut();

    // Streaming at one instruction per cycle from reset.
    p0 = pop_count;
    i0 = popped.size();
    run(10);
    check("stream_rate", 32'(pop_count - p0), 32'd8);
    check("stream_pc0", popped[i0], 32'hBFC0_0000);
    check("stream_pc1", popped[i0+1], 32'hBFC0_0004);
    check("stream_pc2", popped[i0+2], 32'hBFC0_0008);

    // Stalled decode fills the queue, then one pop admits exactly one new request.
    reset_dut();
    i0 = issue_count;
    repeat (8) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("full_issues", 32'(issue_count - i0), 32'd4);
    i0 = issue_count;
    p0 = pop_count;
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("full_pop_issue", 32'(issue_count - i0), 32'd1);
    check("full_pop_count", 32'(pop_count - p0), 32'd1);

    // Branch with three requests outstanding.
    reset_dut();
    repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 32'h8000_1000, 1'b1, 1'b0, 1'b0);
    i0 = popped.size();
    run(12);
    check("branch_first_pc", popped[i0], 32'h8000_1000);

    // Exception beats branch in a cycle that also carries a response.
    reset_dut();
    repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hBFC0_0380, 1'b1, 32'h8000_1000, 1'b1, 1'b1, 1'b1);
    i0 = popped.size();
    run(12);
    check("except_first_pc", popped[i0], 32'hBFC0_0380);

    // Fetch address wraps past the top of the address space.
    reset_dut();
    cycle(1'b0, '0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
    i0 = popped.size();
    run(10);
    check("wrap_pc0", popped[i0], 32'hFFFF_FFF8);
    check("wrap_pc2", popped[i0+2], 32'h0000_0000);

    // Reset with two pending slots and one filled slot.
    reset_dut();
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_dut();
    i0 = popped.size();
    run(4);
    check("restart_pc", popped[i0], RESET_PC);

    // Randomized traffic with redirects and a mid-run reset.
    p0 = pop_count;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) reset_dut();
      rand_cycle();
    end
    check("random_progress", 32'(pop_count - p0 > 300), 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Parameters
REQ-001 DEPTH, 4, number of fetch-buffer slots; SHALL be a power of two, >= 2.
REQ-002 RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Interface
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low; SHALL clear all state while low.
REQ-005 except  in  1  exception redirect request.
REQ-006 except_addr  in  `W_ADDR  exception target.
REQ-007 branch  in  1  branch redirect request.
REQ-008 branch_addr  in  `W_ADDR  branch target.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  `W_ADDR  fetch address.
REQ-011 imem_addr_ok  in  1  request accepted this cycle.
REQ-012 imem_data_ok  in  1  response valid; responses return in request order.
REQ-013 imem_rdata  in  32  response instruction.
REQ-014 out_valid  out  1  instruction available to decode.
REQ-015 out_ready  in  1  decode accepts; low means stall.
REQ-016 out_pc  out  `W_ADDR  PC of head instruction.
REQ-017 out_inst  out  32  head instruction.

Function
REQ-018 Slot states: EMPTY, PENDING (address issued, pc recorded), FILLED (pc+inst); three pointers: alloc, fill, head, each log2(DEPTH)+1 bits (wrap bit).
REQ-019 imem_req SHALL be 1 iff no redirect this cycle and slots in use (PENDING+FILLED) < DEPTH; imem_addr = fetch_pc.
REQ-020 On imem_req & imem_addr_ok: slot[alloc] <= PENDING with fetch_pc; alloc++; fetch_pc += 4 (modulo 2^32).
REQ-021 On imem_data_ok with drop_cnt = 0: slot[fill] <= FILLED with imem_rdata; fill++.
REQ-022 On imem_data_ok with drop_cnt > 0: response discarded; drop_cnt--.
REQ-023 out_valid = slot[head] FILLED; out_pc/out_inst from slot[head], combinational, no added latency.
REQ-024 On out_valid & out_ready: slot[head] <= EMPTY; head++.
REQ-025 Minimum latency: data_ok in cycle N -> out_valid in cycle N+1.
REQ-026 Redirect: except has priority over branch; target = except_addr if except else branch_addr.
REQ-027 Redirect cycle: fetch_pc <= target; all slots EMPTY; alloc = fill = head; imem_req = 0; pop not performed.
REQ-028 Redirect cycle: drop_cnt <= drop_cnt + (PENDING slots) - (1 if data_ok that cycle else 0), counting data_ok first against existing drop_cnt; no corrupted instruction SHALL ever reach out_*.
REQ-029 drop_cnt width log2(DEPTH+1)+1; SHALL never overflow or underflow.
REQ-030 Full (DEPTH slots in use): imem_req = 0 until a pop or redirect frees a slot; pop and issue in the same cycle SHALL both be allowed.
REQ-031 Empty: out_valid = 0; out_pc/out_inst don't-care.
REQ-032 Simultaneous issue, fill, pop on the same pointer wrap boundary SHALL be handled correctly through wrap bits.
REQ-033 Target low two bits SHALL pass through unmodified; alignment checking belongs to decode.

Reset
REQ-034 While rst = 0: fetch_pc = RESET_PC, all slots EMPTY, pointers 0, drop_cnt 0, imem_req 0, out_valid 0.
REQ-035 First request (imem_addr = RESET_PC) in the first cycle after rst rises.
REQ-036 Reset asserted mid-operation SHALL discard all slots and outstanding responses; memory side is reset with the same rst.

Verification
REQ-037 Reset release, addr_ok=1 every cycle, data_ok one cycle later, out_ready=1 -> out_pc sequence BFC00000, BFC00004, BFC00008 at one per cycle.
REQ-038 DEPTH=4, out_ready=0, memory always ready -> exactly 4 requests, then imem_req=0; out_ready=1 one cycle -> one pop, one new request same cycle.
REQ-039 3 requests outstanding, branch=1 branch_addr=80001000 -> next 3 data_ok dropped; first out_pc = 80001000.
REQ-040 except=1 (except_addr=BFC00380) and branch=1 same cycle as a data_ok -> target BFC00380; drop_cnt = outstanding-1; no stale out_valid.
REQ-041 Fetch at FFFFFFFC accepted -> next imem_addr = 00000000.
REQ-042 rst pulled low with 2 pending and 1 filled slot -> out_valid=0, imem_req=0 immediately; restart at RESET_PC.
